// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM state, stage indices and hold/kill output patterns for pipe_hazard_ctrl
package pipe_ctrl_pkg;
  typedef enum logic {RUN, MULDIV} state_t;
  localparam int STG_IFID = 0;
  localparam int STG_IDEX = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;
  typedef struct packed {
    logic pcHold;
    logic [3:0] hold;
    logic [3:0] kill;
  } hk_t;
  localparam hk_t HK_NONE = '{1'b0, 4'b0000, 4'b0000};
  localparam hk_t HK_RESET = '{1'b0, 4'b0000, 4'b1111};
  localparam hk_t HK_MEMSTALL = '{1'b1, 4'b0111, 4'b1000};
  localparam hk_t HK_MULDIV = '{1'b1, 4'b0011, 4'b0100};
  localparam hk_t HK_BRANCH = '{1'b0, 4'b0000, 4'b0011};
  localparam hk_t HK_LOADUSE = '{1'b1, 4'b0001, 4'b0010};
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from ID/EX/MEM and hold/kill/pc_hold/busy back to the pipeline
//   master = pipeline side (drives hazard sources), slave = controller side
interface pipe_hazard_ctrl_if #(parameter int REG_W = 5);
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use1, id_use2, ex_is_load, ex_is_muldiv, ex_br_taken, mem_req, mem_rdy;
  logic pc_hold, busy;
  logic [3:0] hold, kill;
  modport master(output id_rs1, id_rs2, ex_rd, id_use1, id_use2, ex_is_load, ex_is_muldiv,
                 ex_br_taken, mem_req, mem_rdy, input pc_hold, busy, hold, kill);
  modport slave(input id_rs1, id_rs2, ex_rd, id_use1, id_use2, ex_is_load, ex_is_muldiv,
                ex_br_taken, mem_req, mem_rdy, output pc_hold, busy, hold, kill);
endinterface

// File: rtl/pipe_hazard_ctrl_loaduse.sv
// pipe_loaduse_cmp: load-use detect; EX load writing a register the ID instruction reads (x0 excluded)
//   rs1/rs2/use1/use2: ID sources, rd/isLoad: EX destination, luse: stall request
module pipe_loaduse_cmp #(parameter int REG_W = 5) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             use1,
  input  logic             use2,
  input  logic             isLoad,
  output logic             luse
);
  assign luse = isLoad & (|rd) & ((use1 & (rs1 == rd)) | (use2 & (rs2 == rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for PC and the IF/ID, ID/EX, EX/MEM, MEM/WB registers
//   clk, rst (async, active-low), bus (pipe_hazard_ctrl_if.slave)
//   optional PIPE_HAZARD_PERF_EN: stall_cnt (cycles with pc_hold), flush_cnt (branch flushes)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int REG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    bus
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);
  localparam int CW = $clog2(MD_LAT);
  state_t state;
  logic [CW-1:0] mdCnt;
  logic luse, memStall, mdActive, mdRelease, brHit;
  hk_t hk;
  pipe_loaduse_cmp #(.REG_W(REG_W)) uLuse (
    .rs1(bus.id_rs1), .rs2(bus.id_rs2), .rd(bus.ex_rd),
    .use1(bus.id_use1), .use2(bus.id_use2), .isLoad(bus.ex_is_load), .luse(luse)
  );
  always_comb begin
    memStall = bus.mem_req & ~bus.mem_rdy;
    mdActive = (state == MULDIV) | bus.ex_is_muldiv;
    mdRelease = (state == MULDIV) & (mdCnt == '0);
    brHit = ~memStall & ~mdActive & bus.ex_br_taken;
    hk = !rst ? HK_RESET :
         memStall ? HK_MEMSTALL :
         mdActive ? (mdRelease ? HK_NONE : HK_MULDIV) :
         bus.ex_br_taken ? HK_BRANCH :
         luse ? HK_LOADUSE : HK_NONE;
  end
  assign bus.pc_hold = hk.pcHold;
  assign bus.hold = hk.hold;
  assign bus.kill = hk.kill;
  assign bus.busy = (state == MULDIV);
  // A data-memory wait freezes the mul/div countdown so the op still gets MD_LAT real EX cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      mdCnt <= '0;
    end else if (!memStall) begin
      if (state == RUN) begin
        if (bus.ex_is_muldiv) begin
          state <= MULDIV;
          mdCnt <= CW'(MD_LAT - 2);
        end
      end else if (mdCnt == '0) begin
        state <= RUN;
      end else begin
        mdCnt <= mdCnt - CW'(1);
      end
    end
  end
`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, hk.pcHold};
      flush_cnt <= flush_cnt + {31'd0, brHit};
    end
  end
`endif
  holdKillExclusive: assert property (@(posedge clk) disable iff (!rst) (bus.hold & bus.kill) == 4'b0);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against an EX-occupancy model
module tb_pipe_hazard_ctrl;
  localparam int MD_LAT = 4;
  localparam int REG_W = 5;
  logic clk = 1'b1;
  logic rst = 1'b1;
  int nChecks = 0;
  int nFails = 0;
  int occ = 0;
  int nStall = 0;
  int nFlush = 0;
  logic [5:0] fetch;
  logic [5:0] pr [4];
  always #2 clk = ~clk;
  pipe_hazard_ctrl_if #(.REG_W(REG_W)) bus ();
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .REG_W(REG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch <= 6'd1;
      for (int s = 0; s < 4; s++) pr[s] <= '0;
    end else begin
      if (!bus.pc_hold) fetch <= fetch + 6'd1;
      for (int s = 0; s < 4; s++)
        pr[s] <= bus.kill[s] ? 6'd0 : bus.hold[s] ? pr[s] : (s == 0 ? fetch : pr[s-1]);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rd = '0;
    bus.id_use1 = 0; bus.id_use2 = 0; bus.ex_is_load = 0; bus.ex_is_muldiv = 0;
    bus.ex_br_taken = 0; bus.mem_req = 0; bus.mem_rdy = 0;
  endtask
  task automatic step(input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                      input logic [REG_W-1:0] rd, input logic u1, input logic u2,
                      input logic ld, input logic md, input logic br,
                      input logic req, input logic rdy);
    logic ms, mdNow, lu, ep;
    logic [3:0] eh, ek;
    @(negedge clk);
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.ex_rd = rd;
    bus.id_use1 = u1; bus.id_use2 = u2; bus.ex_is_load = ld; bus.ex_is_muldiv = md;
    bus.ex_br_taken = br; bus.mem_req = req; bus.mem_rdy = rdy;
    #1;
    ms = req && !rdy;
    mdNow = occ > 0 || md;
    lu = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (ms) begin ep = 1; eh = 4'b0111; ek = 4'b1000; end
    else if (mdNow && occ + 1 < MD_LAT) begin ep = 1; eh = 4'b0011; ek = 4'b0100; end
    else if (mdNow) begin ep = 0; eh = 4'b0000; ek = 4'b0000; end
    else if (br) begin ep = 0; eh = 4'b0000; ek = 4'b0011; end
    else if (lu) begin ep = 1; eh = 4'b0001; ek = 4'b0010; end
    else begin ep = 0; eh = 4'b0000; ek = 4'b0000; end
    chk("pc_hold", 32'(bus.pc_hold), 32'(ep));
    chk("hold", 32'(bus.hold), 32'(eh));
    chk("kill", 32'(bus.kill), 32'(ek));
    chk("busy", 32'(bus.busy), 32'(occ > 0));
    if (ep) nStall++;
    if (!ms && !mdNow && br) nFlush++;
    if (!ms && mdNow) occ = (occ + 1 == MD_LAT) ? 0 : occ + 1;
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic nop();
    step('0, '0, '0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    idle();
    #1 rst = 0;
    #1;
    chk("rst_kill", 32'(bus.kill), 32'hF);
    chk("rst_hold", 32'(bus.hold), 32'h0);
    chk("rst_pc_hold", 32'(bus.pc_hold), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("run_kill", 32'(bus.kill), 32'h0);
    chk("run_busy", 32'(bus.busy), 32'h0);
    nop();
    step(5'd5, '0, 5'd5, 1, 0, 1, 0, 0, 0, 0);
    nop();
    step('0, '0, '0, 1, 0, 1, 0, 0, 0, 0);
    nop();
    step(5'd7, 5'd7, 5'd7, 1, 1, 1, 0, 1, 0, 0);
    chk("ifid_bubble", 32'(pr[0]), 32'h0);
    chk("idex_bubble", 32'(pr[1]), 32'h0);
    nop();
    step('0, '0, '0, 0, 0, 0, 1, 0, 0, 0);
    repeat (4) nop();
`ifdef PIPE_HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, 32'd4);
    chk("flush_cnt", flush_cnt, 32'd1);
`endif
    step('0, '0, '0, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) step('0, '0, '0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) nop();
    step('0, '0, '0, 0, 0, 0, 1, 0, 0, 0);
    rst = 0;
    #1;
    chk("async_busy", 32'(bus.busy), 32'h0);
    chk("async_kill", 32'(bus.kill), 32'hF);
    @(negedge clk);
    rst = 1;
    occ = 0;
    nStall = 0;
    nFlush = 0;
    for (int i = 0; i < 400; i++)
      step(REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    nop();
`ifdef PIPE_HAZARD_PERF_EN
    chk("stall_cnt_rand", stall_cnt, 32'(nStall));
    chk("flush_cnt_rand", flush_cnt, 32'(nFlush));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
